// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state enum, opcode constants and control-field encodings for the multicycle MIPS controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC_R, S_EXEC_I, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that hold a memory request and wait for mem_ready
    function automatic logic is_wait_state(input state_t s);
        return s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath/memory signal bundle
//   master (controller): in opcode/zero/mem_ready, out all datapath enables, selects, retire, trap
//   slave  (datapath):   mirror image
interface mc_ctrl_if #(parameter int OPW = 6) ();
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;
    logic           pc_write;
    logic           ir_write;
    logic           iord;
    logic           mem_read;
    logic           mem_write;
    logic           mem_to_reg;
    logic           reg_dst;
    logic           reg_write;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_source;
    logic           retire;
    logic           trap;
    logic [1:0]     trap_cause;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, retire, trap, trap_cause
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, retire, trap, trap_cause
    );
endinterface

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts consecutive memory wait cycles and flags the cycle that hits MEM_TIMEOUT
//   clk, rst_n : clock, async active-low reset
//   i_wait     : controller is in a memory state with mem_ready low
//   o_timeout  : this is the MEM_TIMEOUT-th consecutive wait cycle (never set when MEM_TIMEOUT=0)
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_wait,
    output logic o_timeout
);
    localparam int W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;

    logic [W-1:0] r_cnt;

    // Any non-wait cycle is either a state change or outside a memory state, so it clears the count
    assign o_timeout = (MEM_TIMEOUT != 0) && i_wait && (r_cnt == W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= (i_wait && !o_timeout) ? r_cnt + 1'b1 : '0;
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM (fetch/decode/execute/memory/write-back)
//   clk, rst_n : clock, async active-low reset
//   bus        : mc_ctrl_if master; opcode/zero/mem_ready in, datapath controls, retire, trap out
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int OPW         = 6
) (
    input  logic      clk,
    input  logic      rst_n,
    mc_ctrl_if.master bus
);
    state_t         r_state;
    logic [1:0]     r_cause;
    logic [OPW-1:0] w_op;
    logic           w_wait;
    logic           w_timeout;
    logic           w_taken;

    assign w_op   = bus.opcode;
    assign w_wait = is_wait_state(r_state) && !bus.mem_ready;

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wait    (w_wait),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RST;
            r_cause <= CAUSE_NONE;
        end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_cause <= CAUSE_TIMEOUT;
        end else begin
            case (r_state)
                S_RST:      r_state <= S_FETCH;
                S_FETCH:    if (bus.mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_op == OPW'(OP_LW) || w_op == OPW'(OP_SW)) r_state <= S_MEM_ADDR;
                    else if (w_op == OPW'(OP_RTYPE))                r_state <= S_EXEC_R;
                    else if (w_op == OPW'(OP_ADDI))                 r_state <= S_EXEC_I;
                    else if (w_op == OPW'(OP_BEQ) || w_op == OPW'(OP_BNE)) r_state <= S_BRANCH;
                    else if (w_op == OPW'(OP_J))                    r_state <= S_JUMP;
                    else begin
                        r_state <= S_TRAP;
                        r_cause <= CAUSE_ILLEGAL;
                    end
                end
                S_MEM_ADDR: r_state <= (w_op == OPW'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (bus.mem_ready) r_state <= S_MEM_WB;
                S_MEM_WR:   if (bus.mem_ready) r_state <= S_FETCH;
                S_EXEC_R:   r_state <= S_R_WB;
                S_EXEC_I:   r_state <= S_I_WB;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Branch resolution is the one output that looks at zero combinationally
    assign w_taken = (w_op == OPW'(OP_BEQ) && bus.zero) || (w_op == OPW'(OP_BNE) && !bus.zero);

    assign bus.trap       = (r_state == S_TRAP);
    assign bus.trap_cause = r_cause;

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_RT;
        bus.alu_op     = ALU_ADD;
        bus.pc_source  = PCS_ALU;
        bus.retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE:   bus.alu_src_b = SRCB_IMM_SH;
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.retire     = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                bus.retire    = bus.mem_ready;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                bus.retire    = 1'b1;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_I_WB: begin
                bus.reg_write = 1'b1;
                bus.retire    = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_SUB;
                bus.pc_source = PCS_ALUOUT;
                bus.pc_write  = w_taken;
                bus.retire    = 1'b1;
            end
            S_JUMP: begin
                bus.pc_source = PCS_JUMP;
                bus.pc_write  = 1'b1;
                bus.retire    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
